// File: rtl/ysyx_22050710_sram_arbiter_pkg.sv
// rtl/ysyx_22050710_sram_arbiter_pkg.sv - master IDs and SRAM size encodings shared by the arbiter slice
package ysyx_22050710_sram_arbiter_pkg;

  // Master identifiers; also the bit index into the per-master port vectors.
  localparam logic M_INST = 1'b0;
  localparam logic M_DATA = 1'b1;

  // SRAM-like transfer size encodings carried on *_size.
  localparam logic [1:0] SRAM_SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SRAM_SIZE_HALF  = 2'd1;
  localparam logic [1:0] SRAM_SIZE_WORD  = 2'd2;
  localparam logic [1:0] SRAM_SIZE_DWORD = 2'd3;

  // One-hot per-master strobe for a master id.
  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ysyx_22050710_arb_id_fifo.sv
// rtl/ysyx_22050710_arb_id_fifo.sv - in-order owner FIFO, one bit per outstanding transaction
module ysyx_22050710_arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  logic i_din,
  input  logic i_pop,
  output logic o_dout,
  output logic o_full,
  output logic o_empty
);

  localparam int PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_WD = $clog2(DEPTH + 1);
  localparam logic [PTR_WD-1:0] PTR_LAST = PTR_WD'(DEPTH - 1);
  localparam logic [CNT_WD-1:0] CNT_FULL = CNT_WD'(DEPTH);

  logic [DEPTH-1:0]  r_mem;
  logic [PTR_WD-1:0] r_wr_ptr;
  logic [PTR_WD-1:0] r_rd_ptr;
  logic [CNT_WD-1:0] r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // Pointers wrap at DEPTH-1 explicitly so DEPTH=1 also works.
  function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Full/empty come from the registered count only, so a pop never frees a slot the same cycle.
  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_dout    = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; simultaneous push+pop leaves the count unchanged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22050710_sram_arbiter.sv
// rtl/ysyx_22050710_sram_arbiter.sv - 2:1 SRAM-like arbiter (inst/data), optional round-robin via YSYX_22050710_SRAM_ARB_RR_EN
module ysyx_22050710_sram_arbiter
  import ysyx_22050710_sram_arbiter_pkg::*;
#(
  parameter int SRAM_ADDR_WD    = 32,
  parameter int SRAM_DATA_WD    = 64,
  parameter int SRAM_WMASK_WD   = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [1:0]                 i_m_req,
  input  logic [1:0]                 i_m_op,
  input  logic [3:0]                 i_m_size,
  input  logic [2*SRAM_ADDR_WD-1:0]  i_m_addr,
  input  logic [2*SRAM_WMASK_WD-1:0] i_m_wstrb,
  input  logic [2*SRAM_DATA_WD-1:0]  i_m_wdata,
  output logic [1:0]                 o_m_addr_ok,
  output logic [1:0]                 o_m_data_ok,
  output logic [SRAM_DATA_WD-1:0]    o_m_rdata,
  output logic                       o_sram_req,
  output logic                       o_sram_op,
  output logic [1:0]                 o_sram_size,
  output logic [SRAM_ADDR_WD-1:0]    o_sram_addr,
  output logic [SRAM_WMASK_WD-1:0]   o_sram_wstrb,
  output logic [SRAM_DATA_WD-1:0]    o_sram_wdata,
  input  logic                       i_sram_addr_ok,
  input  logic                       i_sram_data_ok,
  input  logic [SRAM_DATA_WD-1:0]    i_sram_rdata
);

  logic r_lock_valid;
  logic r_lock_id;
  logic w_gnt;
  logic w_gnt_req;
  logic w_full;
  logic w_empty;
  logic w_head;
  logic w_accept;
  logic w_pop;

`ifdef YSYX_22050710_SRAM_ARB_RR_EN
  logic r_rr_last;
`endif

  // Grant: a presented-but-unaccepted request keeps the port; otherwise pick a new master.
  always_comb begin
    w_gnt = M_INST;
    if (r_lock_valid) begin
      w_gnt = r_lock_id;
`ifdef YSYX_22050710_SRAM_ARB_RR_EN
    end else if (i_m_req[M_INST] & i_m_req[M_DATA]) begin
      w_gnt = ~r_rr_last;
    end else if (i_m_req[M_DATA]) begin
      w_gnt = M_DATA;
`else
    end else if (i_m_req[M_DATA]) begin
      w_gnt = M_DATA;
`endif
    end
  end

  // Zero-cycle request path: forward the granted master's fields to the slave.
  always_comb begin
    w_gnt_req    = i_m_req[0];
    o_sram_op    = i_m_op[0];
    o_sram_size  = i_m_size[1:0];
    o_sram_addr  = i_m_addr[SRAM_ADDR_WD-1:0];
    o_sram_wstrb = i_m_wstrb[SRAM_WMASK_WD-1:0];
    o_sram_wdata = i_m_wdata[SRAM_DATA_WD-1:0];
    if (w_gnt) begin
      w_gnt_req    = i_m_req[1];
      o_sram_op    = i_m_op[1];
      o_sram_size  = i_m_size[3:2];
      o_sram_addr  = i_m_addr[2*SRAM_ADDR_WD-1:SRAM_ADDR_WD];
      o_sram_wstrb = i_m_wstrb[2*SRAM_WMASK_WD-1:SRAM_WMASK_WD];
      o_sram_wdata = i_m_wdata[2*SRAM_DATA_WD-1:SRAM_DATA_WD];
    end
  end

  assign o_sram_req  = w_gnt_req & ~w_full & ~i_rst;
  assign w_accept    = o_sram_req & i_sram_addr_ok;
  assign o_m_addr_ok = w_accept ? id_onehot(w_gnt) : 2'b00;

  // Responses return in order; the FIFO head names the master that owns this data_ok.
  assign w_pop       = i_sram_data_ok & ~w_empty & ~i_rst;
  assign o_m_data_ok = w_pop ? id_onehot(w_head) : 2'b00;
  assign o_m_rdata   = i_sram_rdata;

  // Lock holds the grant while the slave stalls; dropping req releases it next cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lock_valid <= 1'b0;
      r_lock_id    <= M_INST;
    end else begin
      r_lock_valid <= o_sram_req & ~i_sram_addr_ok;
      r_lock_id    <= w_gnt;
    end
  end

`ifdef YSYX_22050710_SRAM_ARB_RR_EN
  // Round-robin history: remember the last master whose address was accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_last <= M_DATA;
    end else if (w_accept) begin
      r_rr_last <= w_gnt;
    end
  end
`endif

  ysyx_22050710_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_accept),
    .i_din   (w_gnt),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A slave data_ok with nothing outstanding is dropped; flag it in simulation.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      a_no_orphan_data_ok: assert (!(i_sram_data_ok && w_empty));
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// tb/tb_ysyx_22050710_sram_arbiter.sv - randomized scoreboard bench for the SRAM arbiter
module tb_ysyx_22050710_sram_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int MW   = 8;
  localparam int MAXO = 2;

  logic              clk = 1'b0;
  logic              i_rst;
  logic [1:0]        i_m_req;
  logic [1:0]        i_m_op;
  logic [3:0]        i_m_size;
  logic [2*AW-1:0]   i_m_addr;
  logic [2*MW-1:0]   i_m_wstrb;
  logic [2*DW-1:0]   i_m_wdata;
  logic [1:0]        o_m_addr_ok;
  logic [1:0]        o_m_data_ok;
  logic [DW-1:0]     o_m_rdata;
  logic              o_sram_req;
  logic              o_sram_op;
  logic [1:0]        o_sram_size;
  logic [AW-1:0]     o_sram_addr;
  logic [MW-1:0]     o_sram_wstrb;
  logic [DW-1:0]     o_sram_wdata;
  logic              i_sram_addr_ok;
  logic              i_sram_data_ok;
  logic [DW-1:0]     i_sram_rdata;

  always #5 clk = ~clk;

  ysyx_22050710_sram_arbiter #(
    .SRAM_ADDR_WD    (AW),
    .SRAM_DATA_WD    (DW),
    .SRAM_WMASK_WD   (MW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_m_req        (i_m_req),
    .i_m_op         (i_m_op),
    .i_m_size       (i_m_size),
    .i_m_addr       (i_m_addr),
    .i_m_wstrb      (i_m_wstrb),
    .i_m_wdata      (i_m_wdata),
    .o_m_addr_ok    (o_m_addr_ok),
    .o_m_data_ok    (o_m_data_ok),
    .o_m_rdata      (o_m_rdata),
    .o_sram_req     (o_sram_req),
    .o_sram_op      (o_sram_op),
    .o_sram_size    (o_sram_size),
    .o_sram_addr    (o_sram_addr),
    .o_sram_wstrb   (o_sram_wstrb),
    .o_sram_wdata   (o_sram_wdata),
    .i_sram_addr_ok (i_sram_addr_ok),
    .i_sram_data_ok (i_sram_data_ok),
    .i_sram_rdata   (i_sram_rdata)
  );

  typedef struct {
    bit          id;
    logic [63:0] rdata;
  } exp_t;

  int tests = 0;
  int fails = 0;

  // Masters: each holds one request until accepted (or occasionally abandons it).
  bit          pend [2];
  logic        mop  [2];
  logic [1:0]  msize[2];
  logic [31:0] maddr[2];
  logic [7:0]  mstrb[2];
  logic [63:0] mdata[2];

  // Reference state: who keeps the port after a stall, round-robin history,
  // transactions the slave holds, and responses each master should see.
  bit          mdl_lock_valid;
  bit          mdl_lock_id;
  bit          mdl_rr_last;
  logic [63:0] inflight[$];
  exp_t        exp_q[$];

  function automatic logic [63:0] slave_data(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_masters();
    i_m_req   = {pend[1], pend[0]};
    i_m_op    = {mop[1], mop[0]};
    i_m_size  = {msize[1], msize[0]};
    i_m_addr  = {maddr[1], maddr[0]};
    i_m_wstrb = {mstrb[1], mstrb[0]};
    i_m_wdata = {mdata[1], mdata[0]};
  endtask

  // One bus cycle: randomize masters and slave, compare the request path, update the model.
  task automatic do_cycle(input bit rst_c, input int new_pct, input int aok_pct, input int dok_pct);
    bit   g;
    bit   want;
    bit   exp_req;
    bit   dok;
    exp_t e;
    @(negedge clk);
    i_rst = rst_c;
    for (int m = 0; m < 2; m++) begin
      if (!pend[m]) begin
        if ($urandom_range(0, 99) < new_pct) begin
          pend[m]  = 1'b1;
          mop[m]   = 1'($urandom_range(0, 1));
          msize[m] = 2'($urandom_range(0, 3));
          maddr[m] = {($urandom_range(0, 1) != 0) ? 8'h80 : 8'h10, 21'($urandom), 3'b000};
          mstrb[m] = 8'($urandom);
          mdata[m] = {32'($urandom), 32'($urandom)};
        end
      end else if (!rst_c && $urandom_range(0, 15) == 0) begin
        pend[m] = 1'b0;
      end
    end
    drive_masters();
    i_sram_addr_ok = ($urandom_range(0, 99) < aok_pct);
    dok = rst_c ? ($urandom_range(0, 1) != 0) : (inflight.size() > 0 && $urandom_range(0, 99) < dok_pct);
    i_sram_data_ok = dok;
    i_sram_rdata   = (dok && inflight.size() > 0) ? inflight[0] : {32'($urandom), 32'($urandom)};
    #1;
    if (rst_c) begin
      check("rst_sram_req", 128'(o_sram_req), 128'(0));
      check("rst_addr_ok", 128'(o_m_addr_ok), 128'(0));
      check("rst_data_ok", 128'(o_m_data_ok), 128'(0));
      inflight.delete();
      exp_q.delete();
      mdl_lock_valid = 1'b0;
      mdl_rr_last    = 1'b1;
      return;
    end
    // Which master should own the port this cycle.
    if (mdl_lock_valid) g = mdl_lock_id;
`ifdef YSYX_22050710_SRAM_ARB_RR_EN
    else if (pend[0] && pend[1]) g = ~mdl_rr_last;
`endif
    else g = pend[1];
    want    = pend[g];
    exp_req = want && (inflight.size() < MAXO);
    check("sram_req", 128'(o_sram_req), 128'(exp_req));
    check("addr_ok", 128'(o_m_addr_ok), 128'((exp_req && i_sram_addr_ok) ? (g ? 2'b10 : 2'b01) : 2'b00));
    if (exp_req)
      check("sram_fields", 128'({o_sram_op, o_sram_size, o_sram_addr, o_sram_wstrb, o_sram_wdata}),
            128'({mop[g], msize[g], maddr[g], mstrb[g], mdata[g]}));
    if (dok) void'(inflight.pop_front());
    if (exp_req && i_sram_addr_ok) begin
      inflight.push_back(slave_data(o_sram_addr));
      e.id    = g;
      e.rdata = slave_data(maddr[g]);
      exp_q.push_back(e);
      pend[g]     = 1'b0;
      mdl_rr_last = g;
    end
    mdl_lock_valid = exp_req && !i_sram_addr_ok;
    mdl_lock_id    = g;
  endtask

  // Monitor: every response the DUT presents must match the oldest expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (i_rst !== 1'b0) continue;
      if (o_m_data_ok != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("data_ok_unexpected", 128'(o_m_data_ok), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("data_ok_owner", 128'(o_m_data_ok), 128'(e.id ? 2'b10 : 2'b01));
          check("rdata", 128'(o_m_rdata), 128'(e.rdata));
        end
      end
    end
  end

  initial begin
    int guard;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; mop[m] = 1'b0; msize[m] = 2'd0;
      maddr[m] = '0; mstrb[m] = '0; mdata[m] = '0;
    end
    mdl_lock_valid = 1'b0;
    mdl_lock_id    = 1'b0;
    mdl_rr_last    = 1'b1;
    i_rst = 1'b1;
    drive_masters();
    i_sram_addr_ok = 1'b0;
    i_sram_data_ok = 1'b0;
    i_sram_rdata   = '0;
    // Reset with both masters requesting and the slave handshaking: outputs stay quiet.
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 100, 100, 100);
    // Mixed traffic with stalls, back-pressure and full-FIFO phases.
    for (int i = 0; i < 1200; i++) do_cycle(1'b0, 40, 60, 50);
    // Reset in the middle of traffic flushes outstanding state.
    for (int i = 0; i < 2; i++) do_cycle(1'b1, 50, 100, 100);
    for (int i = 0; i < 800; i++) do_cycle(1'b0, 70, 90, 30);
    for (int i = 0; i < 800; i++) do_cycle(1'b0, 90, 100, 100);
    for (int i = 0; i < 400; i++) do_cycle(1'b0, 60, 30, 80);
    // Drain: no new requests, slave answers everything.
    guard = 0;
    while ((inflight.size() > 0 || pend[0] || pend[1]) && guard < 50) begin
      do_cycle(1'b0, 0, 100, 100);
      guard++;
    end
    do_cycle(1'b0, 0, 100, 100);
    check("drain_within_bound", 128'(guard < 50), 128'(1));
    check("responses_outstanding", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
